// File: rtl/accumulator.sv
// Running-total accumulator: adds the unsigned addend A into a registered
// sum on every rising clock edge, with either modulo wrap or saturation at
// all-ones, and a sticky overflow flag that records any carry-out since the
// last reset.
module accumulator #(
  parameter int WIDTH    = 32,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] sum,
  output logic             ovf
);

  // One bit wider than the operands so the carry-out is kept rather than lost.
  logic [WIDTH:0]   full_sum;
  logic             carry;
  logic [WIDTH-1:0] next_sum;

  // Form the true sum and pick the wrapped or clamped value for the next total.
  always_comb begin
    // NOTE: every always_comb output gets a default before any branch, so a
    // missing else can never leave a value held and infer a latch.
    next_sum = '0;
    full_sum = {1'b0, sum} + {1'b0, A};
    carry    = full_sum[WIDTH];
    if (SATURATE && carry) begin
      next_sum = '1;
    end else begin
      next_sum = full_sum[WIDTH-1:0];
    end
  end

  // Register the running total and the sticky overflow flag; reset wins.
  always_ff @(posedge clk) begin
    // NOTE: state is written with <= so every register samples the values
    // from before the edge; blocking = here would create order-dependent races.
    if (rst) begin
      sum <= '0;
      ovf <= 1'b0;
    end else begin
      sum <= next_sum;
      ovf <= ovf | carry;
    end
  end

endmodule

// File: tb/tb_accumulator.sv
// Directed bench for accumulator: one wrapping and one saturating instance
// share clock and inputs; a table of vectors is applied edge by edge, then a
// hand-written sequence covers reset asserted between edges.
module tb_accumulator;

  localparam int WIDTH = 32;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] sum_wrap;
  logic             ovf_wrap;
  logic [WIDTH-1:0] sum_sat;
  logic             ovf_sat;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic             rst;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] exp_sum_wrap;
    logic             exp_ovf_wrap;
    logic [WIDTH-1:0] exp_sum_sat;
    logic             exp_ovf_sat;
    string            name;
  } vec_t;

  vec_t vecs[$];

  accumulator #(.WIDTH(WIDTH), .SATURATE(1'b0)) u_wrap (
    .clk (clk),
    .rst (rst),
    .A   (a),
    .sum (sum_wrap),
    .ovf (ovf_wrap)
  );

  accumulator #(.WIDTH(WIDTH), .SATURATE(1'b1)) u_sat (
    .clk (clk),
    .rst (rst),
    .A   (a),
    .sum (sum_sat),
    .ovf (ovf_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] actual,
                       input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic add(input logic r, input logic [WIDTH-1:0] av,
                     input logic [WIDTH-1:0] s0, input logic o0,
                     input logic [WIDTH-1:0] s1, input logic o1,
                     input string name);
    vec_t v;
    v.rst = r; v.a = av;
    v.exp_sum_wrap = s0; v.exp_ovf_wrap = o0;
    v.exp_sum_sat  = s1; v.exp_ovf_sat  = o1;
    v.name = name;
    vecs.push_back(v);
  endtask

  task automatic check_all(input string name,
                           input logic [WIDTH-1:0] s0, input logic o0,
                           input logic [WIDTH-1:0] s1, input logic o1);
    check({name, " sum_wrap"}, 64'(sum_wrap), 64'(s0));
    check({name, " ovf_wrap"}, 64'(ovf_wrap), 64'(o0));
    check({name, " sum_sat"},  64'(sum_sat),  64'(s1));
    check({name, " ovf_sat"},  64'(ovf_sat),  64'(o1));
  endtask

  initial begin
    rst = 1'b1;
    a   = '0;

    //   rst  A             sum_wrap      ovf sum_sat       ovf
    add(1'b1, 32'h1234,     32'h0,        0, 32'h0,        0, "reset");
    add(1'b0, 32'd1,        32'd1,        0, 32'd1,        0, "const1");
    add(1'b0, 32'd1,        32'd2,        0, 32'd2,        0, "const2");
    add(1'b0, 32'd1,        32'd3,        0, 32'd3,        0, "const3");
    add(1'b1, 32'd0,        32'd0,        0, 32'd0,        0, "reset2");
    add(1'b0, 32'd1,        32'd1,        0, 32'd1,        0, "ramp1");
    add(1'b0, 32'd2,        32'd3,        0, 32'd3,        0, "ramp2");
    add(1'b0, 32'd3,        32'd6,        0, 32'd6,        0, "ramp3");
    add(1'b0, 32'd4,        32'd10,       0, 32'd10,       0, "ramp4");
    add(1'b1, 32'd0,        32'd0,        0, 32'd0,        0, "reset3");
    add(1'b0, 32'd4,        32'd4,        0, 32'd4,        0, "mid_acc1");
    add(1'b0, 32'd5,        32'd9,        0, 32'd9,        0, "mid_acc2");
    add(1'b1, 32'd5,        32'd0,        0, 32'd0,        0, "mid_rst");
    add(1'b0, 32'd5,        32'd5,        0, 32'd5,        0, "post_rst");
    add(1'b1, 32'd7,        32'd0,        0, 32'd0,        0, "rst_hold1");
    add(1'b1, 32'd9,        32'd0,        0, 32'd0,        0, "rst_hold2");
    add(1'b0, 32'hFFFFFFFE, 32'hFFFFFFFE, 0, 32'hFFFFFFFE, 0, "load_fe");
    add(1'b0, 32'd3,        32'h00000001, 1, 32'hFFFFFFFF, 1, "wrap");
    add(1'b0, 32'd0,        32'h00000001, 1, 32'hFFFFFFFF, 1, "hold_a0");
    add(1'b1, 32'd0,        32'd0,        0, 32'd0,        0, "rst_clr_ovf");
    add(1'b0, 32'hFFFFFFFE, 32'hFFFFFFFE, 0, 32'hFFFFFFFE, 0, "load_fe2");
    add(1'b0, 32'd1,        32'hFFFFFFFF, 0, 32'hFFFFFFFF, 0, "exact_max");
    add(1'b0, 32'd0,        32'hFFFFFFFF, 0, 32'hFFFFFFFF, 0, "max_hold");
    add(1'b0, 32'd1,        32'h00000000, 1, 32'hFFFFFFFF, 1, "max_plus1");
    add(1'b1, 32'd0,        32'd0,        0, 32'd0,        0, "reset4");
    add(1'b0, 32'hFFFFFFF0, 32'hFFFFFFF0, 0, 32'hFFFFFFF0, 0, "load_f0");
    add(1'b0, 32'h20,       32'h00000010, 1, 32'hFFFFFFFF, 1, "sat");
    add(1'b0, 32'd1,        32'h00000011, 1, 32'hFFFFFFFF, 1, "sat_more");
    add(1'b0, 32'd2,        32'h00000013, 1, 32'hFFFFFFFF, 1, "sticky");
    add(1'b1, 32'hFFFF,     32'd0,        0, 32'd0,        0, "reset5");

    foreach (vecs[i]) begin
      @(negedge clk);
      rst = vecs[i].rst;
      a   = vecs[i].a;
      @(posedge clk);
      #1;
      check_all(vecs[i].name, vecs[i].exp_sum_wrap, vecs[i].exp_ovf_wrap,
                vecs[i].exp_sum_sat, vecs[i].exp_ovf_sat);
    end

    // Reset and A changing between edges must not disturb the outputs.
    @(negedge clk);
    rst = 1'b0;
    a   = 32'd7;
    @(posedge clk);
    #1;
    check_all("pre_async", 32'd7, 1'b0, 32'd7, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    a   = 32'd100;
    #2;
    check_all("between_edges", 32'd7, 1'b0, 32'd7, 1'b0);
    @(posedge clk);
    #1;
    check_all("rst_at_edge", 32'd0, 1'b0, 32'd0, 1'b0);

    // First edge out of reset takes exactly the sampled A.
    @(negedge clk);
    rst = 1'b0;
    a   = 32'h0ABC;
    @(posedge clk);
    #1;
    check_all("first_after_rst", 32'h0ABC, 1'b0, 32'h0ABC, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/accumulator.md
ACCUMULATOR -- requirements
Module: accumulator

Interface
REQ-001 Parameter WIDTH, default 32: data width of A and sum.
REQ-002 Parameter SATURATE, default 0: 0 = modulo wrap on overflow; 1 = clamp at all-ones.
REQ-003 clk  input  1  single clock; all state updates on rising edge only.
REQ-004 rst  input  1  reset, synchronous, active-high; sampled on rising clk edge.
REQ-005 A  input  WIDTH  unsigned addend, sampled every rising clk edge.
REQ-006 sum  output  WIDTH  registered running total, unsigned.
REQ-007 ovf  output  1  sticky overflow flag, registered; may be left unconnected by instantiators.

Function
REQ-008 On each rising clk edge with rst=0: sum <= sum + A, both treated as WIDTH-bit unsigned.
REQ-009 Latency: one cycle; the value of A sampled at edge n is included in sum after edge n, visible until edge n+1.
REQ-010 sum SHALL be driven directly from a register; no combinational path from A or rst to sum or ovf.
REQ-011 SATURATE=0: the sum is computed modulo 2^WIDTH (e.g. 0xFFFFFFFF + 1 -> 0x00000000).
REQ-012 SATURATE=1: if the WIDTH+1-bit true sum exceeds 2^WIDTH-1, sum <= all-ones; otherwise sum <= true sum.
REQ-013 ovf SHALL be set on any edge where the WIDTH+1-bit addition carries out, in either mode.
REQ-014 Once set, ovf SHALL remain 1 until reset.
REQ-015 A=0 SHALL hold sum unchanged; ovf is unaffected.
REQ-016 No enable input: accumulation occurs on every non-reset edge.
REQ-017 A SHALL be treated as unknown-free; X on A is outside the contract.

Reset
REQ-018 When rst=1 at a rising edge: sum <= 0 and ovf <= 0, regardless of A.
REQ-019 rst SHALL have priority over accumulation; the A sampled on a reset edge is discarded.
REQ-020 On the first edge with rst=0 after reset: sum <= 0 + A.
REQ-021 Reset asserted mid-accumulation SHALL clear state on that edge with no residual carry or partial sum.
REQ-022 rst held high for multiple edges SHALL keep sum=0 and ovf=0.
REQ-023 Asserting rst between edges SHALL NOT change outputs before the next rising edge.
REQ-024 Power-up register contents before the first reset are unspecified; the bench SHALL apply reset first.

Verification
REQ-025 Reset: apply rst=1 for 1 edge with A=0x1234 -> sum=0, ovf=0 after that edge.
REQ-026 Constant input: after reset, A=1 for 3 edges -> sum = 1, 2, 3 after successive edges.
REQ-027 Ramp input: A=1,2,3,4 on successive edges after reset -> sum = 1, 3, 6, 10.
REQ-028 Mid-run reset: accumulate to 9, then rst=1 for one edge with A=5, then rst=0 with A=5 -> sum = 0, then 5.
REQ-029 Wrap (SATURATE=0): sum=0xFFFFFFFE, then A=3 -> sum=0x00000001 and ovf=1; then A=0 -> sum unchanged and ovf stays 1.
REQ-030 Saturate (SATURATE=1): sum=0xFFFFFFF0, then A=0x20 -> sum=0xFFFFFFFF and ovf=1; a further A=1 keeps sum=0xFFFFFFFF.
